// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, presents it to a combinational-read instruction
// memory and registers the returned word into the IF/ID register with a valid bit.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rd_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o,
    output logic        halted_o,
    output logic        fault_o,
    output logic [31:0] fetch_count_o
);
    typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [32:0] LIMIT  = 33'(IMEM_DEPTH) * 33'd4;

    state_t      state;
    logic [31:0] pc;
    logic        out_of_range;
    logic        unused_ok;

    assign imem_addr_o  = pc;
    assign out_of_range = {1'b0, pc} >= LIMIT;
    assign halted_o     = (state == HALT);
    assign fault_o      = (state == FAULT);
    // Redirect targets are word-aligned by dropping the low bits.
    assign unused_ok    = ^redirect_pc_i[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            pc            <= RESET_PC;
            instr_o       <= NOP;
            pc_o          <= '0;
            pc_plus4_o    <= '0;
            valid_o       <= 1'b0;
            fetch_count_o <= '0;
        end else if (redirect_i) begin
            state   <= RUN;
            pc      <= {redirect_pc_i[31:2], 2'b00};
            instr_o <= NOP;
            valid_o <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    // Range check wins over EBREAK decode: the word is garbage.
                    if (!stall_i && out_of_range) begin
                        state   <= FAULT;
                        instr_o <= NOP;
                        valid_o <= 1'b0;
                    end else if (!stall_i) begin
                        instr_o       <= imem_rd_i;
                        pc_o          <= pc;
                        pc_plus4_o    <= pc + 32'd4;
                        valid_o       <= 1'b1;
                        fetch_count_o <= fetch_count_o + 32'd1;
                        if (imem_rd_i == EBREAK)
                            state <= HALT;
                        else
                            pc <= pc + 32'd4;
                    end
                end
                default: begin
                    instr_o <= NOP;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written corner
// sequences (fault on a shallow memory, reset during HALT) and a randomized model run.
module tb_fetch_stage;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];

    // main DUT, IMEM_DEPTH = 1024
    logic        rst, stall, redir;
    logic [31:0] rpc, addr, rd, instr, pco, pc4, cnt;
    logic        valid, halted, fault;

    // shallow DUT, IMEM_DEPTH = 4; beyond its range memory returns EBREAK
    logic        s_rst, s_stall, s_redir;
    logic [31:0] s_rpc, s_addr, s_rd, s_instr, s_pco, s_pc4, s_cnt;
    logic        s_valid, s_halted, s_fault;

    assign rd   = (addr < 32'd4096) ? mem[addr[11:2]] : 32'hDEAD_BEEF;
    assign s_rd = (s_addr < 32'd16) ? mem[s_addr[11:2]] : EBREAK;

    fetch_stage #(.RESET_PC(32'h0), .IMEM_DEPTH(1024)) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redir), .redirect_pc_i(rpc),
        .imem_addr_o(addr), .imem_rd_i(rd), .instr_o(instr), .pc_o(pco),
        .pc_plus4_o(pc4), .valid_o(valid), .halted_o(halted), .fault_o(fault),
        .fetch_count_o(cnt));

    fetch_stage #(.RESET_PC(32'h0), .IMEM_DEPTH(4)) sdut (
        .clk(clk), .rst(s_rst), .stall_i(s_stall), .redirect_i(s_redir), .redirect_pc_i(s_rpc),
        .imem_addr_o(s_addr), .imem_rd_i(s_rd), .instr_o(s_instr), .pc_o(s_pco),
        .pc_plus4_o(s_pc4), .valid_o(s_valid), .halted_o(s_halted), .fault_o(s_fault),
        .fetch_count_o(s_cnt));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " addr"},   addr,   32'h0);
        chk({tag, " instr"},  instr,  NOP);
        chk({tag, " pc"},     pco,    32'h0);
        chk({tag, " pc4"},    pc4,    32'h0);
        chk({tag, " valid"},  32'(valid),  32'h0);
        chk({tag, " halted"}, 32'(halted), 32'h0);
        chk({tag, " fault"},  32'(fault),  32'h0);
        chk({tag, " count"},  cnt,    32'h0);
    endtask

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        e_valid;
        logic        e_halt;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_addr;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs [14];

    // behavioural reference for the random phase
    logic [31:0] m_pc, m_instr, m_pco, m_pc4, m_cnt;
    logic        m_valid, m_halt, m_fault;

    task automatic model_step(input logic r, input logic st, input logic rd_i, input logic [31:0] tgt);
        logic [31:0] w;
        if (r) begin
            m_pc = 0; m_instr = NOP; m_pco = 0; m_pc4 = 0; m_cnt = 0;
            m_valid = 0; m_halt = 0; m_fault = 0;
        end else if (rd_i) begin
            m_pc = {tgt[31:2], 2'b00}; m_instr = NOP; m_valid = 0; m_halt = 0; m_fault = 0;
        end else if (m_halt || m_fault) begin
            m_valid = 0; m_instr = NOP;
        end else if (m_pc >= 32'd4096) begin
            if (!st) begin m_fault = 1; m_valid = 0; m_instr = NOP; end
        end else if (!st) begin
            w = mem[m_pc[11:2]];
            m_instr = w; m_pco = m_pc; m_pc4 = m_pc + 4; m_valid = 1; m_cnt = m_cnt + 1;
            if (w == EBREAK) m_halt = 1;
            else m_pc = m_pc + 4;
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = NOP;
        mem[0] = 32'h0050_0093; mem[1] = 32'h00A0_0113; mem[2] = 32'h0020_81B3;
        mem[3] = 32'h0000_0013; mem[4] = EBREAK;      mem[16] = 32'h00B0_0193;

        vecs[0]  = '{0, 0, 0,     1, 0, 32'h00, 32'h0050_0093, 32'h04, 1};
        vecs[1]  = '{0, 0, 0,     1, 0, 32'h04, 32'h00A0_0113, 32'h08, 2};
        vecs[2]  = '{1, 0, 0,     1, 0, 32'h04, 32'h00A0_0113, 32'h08, 2};
        vecs[3]  = '{1, 0, 0,     1, 0, 32'h04, 32'h00A0_0113, 32'h08, 2};
        vecs[4]  = '{1, 0, 0,     1, 0, 32'h04, 32'h00A0_0113, 32'h08, 2};
        vecs[5]  = '{0, 0, 0,     1, 0, 32'h08, 32'h0020_81B3, 32'h0C, 3};
        vecs[6]  = '{0, 0, 0,     1, 0, 32'h0C, NOP,           32'h10, 4};
        vecs[7]  = '{0, 0, 0,     1, 1, 32'h10, EBREAK,        32'h10, 5};
        vecs[8]  = '{0, 0, 0,     0, 1, 32'h10, NOP,           32'h10, 5};
        vecs[9]  = '{1, 0, 0,     0, 1, 32'h10, NOP,           32'h10, 5};
        vecs[10] = '{1, 1, 32'h42, 0, 0, 32'h10, NOP,          32'h40, 5};
        vecs[11] = '{0, 0, 0,     1, 0, 32'h40, 32'h00B0_0193, 32'h44, 6};
        vecs[12] = '{0, 1, 0,     0, 0, 32'h40, NOP,           32'h00, 6};
        vecs[13] = '{0, 0, 0,     1, 0, 32'h00, 32'h0050_0093, 32'h04, 7};

        rst = 1; stall = 0; redir = 0; rpc = 0;
        s_rst = 1; s_stall = 0; s_redir = 0; s_rpc = 0;
        tick();
        check_reset("reset");
        rst = 0;

        foreach (vecs[i]) begin
            stall = vecs[i].stall; redir = vecs[i].redir; rpc = vecs[i].rpc;
            tick();
            chk($sformatf("v%0d valid", i), 32'(valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d halted", i), 32'(halted), 32'(vecs[i].e_halt));
            chk($sformatf("v%0d pc", i), pco, vecs[i].e_pc);
            chk($sformatf("v%0d pc4", i), pc4, vecs[i].e_pc + 32'd4);
            chk($sformatf("v%0d instr", i), instr, vecs[i].e_instr);
            chk($sformatf("v%0d addr", i), addr, vecs[i].e_addr);
            chk($sformatf("v%0d count", i), cnt, vecs[i].e_cnt);
        end
        stall = 0; redir = 0;

        // reset while halted
        redir = 1; rpc = 32'h10; tick();
        redir = 0; tick();
        chk("pre-rst halted", 32'(halted), 32'h1);
        rst = 1; tick();
        check_reset("rst in halt");
        rst = 0; tick();
        chk("restart pc", pco, 32'h0);
        chk("restart valid", 32'(valid), 32'h1);
        chk("restart instr", instr, 32'h0050_0093);

        // shallow memory: runs off the end, fault wins over EBREAK at 0x10
        s_rst = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("s pc12", s_pco, 32'h0C);
        chk("s cnt4", s_cnt, 32'd4);
        tick();
        chk("s fault", 32'(s_fault), 32'h1);
        chk("s halted", 32'(s_halted), 32'h0);
        chk("s valid", 32'(s_valid), 32'h0);
        chk("s instr", s_instr, NOP);
        chk("s addr", s_addr, 32'h10);
        chk("s cnt", s_cnt, 32'd4);
        tick();
        chk("s fault hold", 32'(s_fault), 32'h1);
        chk("s addr hold", s_addr, 32'h10);
        s_redir = 1; s_rpc = 32'h4; tick();
        s_redir = 0;
        chk("s fault clr", 32'(s_fault), 32'h0);
        chk("s redirect addr", s_addr, 32'h4);
        tick();
        chk("s after redirect pc", s_pco, 32'h4);

        // randomized run against the model
        for (int i = 0; i < 1024; i++)
            mem[i] = ($urandom_range(7) == 0) ? EBREAK : $urandom;
        rst = 1; model_step(1, 0, 0, 0); tick(); rst = 0;
        for (int c = 0; c < 3000; c++) begin
            logic r, st, rdr;
            logic [31:0] t;
            r   = ($urandom_range(99) == 0);
            st  = ($urandom_range(4) == 0);
            rdr = ($urandom_range(7) == 0);
            t   = ($urandom_range(3) == 0) ? $urandom_range(4000, 4200) : $urandom_range(0, 4095);
            rst = r; stall = st; redir = rdr; rpc = t;
            model_step(r, st, rdr, t);
            tick();
            checks++;
            if ({addr, instr, pco, pc4, cnt, valid, halted, fault} !==
                {m_pc, m_instr, m_pco, m_pc4, m_cnt, m_valid, m_halt, m_fault}) begin
                errors++;
                $display("FAIL rand c%0d: got addr=%h instr=%h pc=%h pc4=%h cnt=%0d v=%b h=%b f=%b expected addr=%h instr=%h pc=%h pc4=%h cnt=%0d v=%b h=%b f=%b",
                         c, addr, instr, pco, pc4, cnt, valid, halted, fault,
                         m_pc, m_instr, m_pco, m_pc4, m_cnt, m_valid, m_halt, m_fault);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
